// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI line-fetch block: raster size,
// RGB565 field layout and the fetch FSM encoding.
package hdmi_pkg;

    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned V_ACTIVE = 720;

    localparam int unsigned PIX_W  = 11;
    localparam int unsigned LINE_W = 10;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned RAM_AW = PIX_W + 1;

    localparam int unsigned RED_MSB = 15;
    localparam int unsigned RED_LSB = 11;
    localparam int unsigned GRN_MSB = 10;
    localparam int unsigned GRN_LSB = 5;
    localparam int unsigned BLU_MSB = 4;
    localparam int unsigned BLU_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    // Field order matches the bounds above, so a cast splits a pixel word.
    typedef struct packed {
        logic [RED_MSB-RED_LSB:0] red;
        logic [GRN_MSB-GRN_LSB:0] green;
        logic [BLU_MSB-BLU_LSB:0] blue;
    } rgb565_t;

endpackage

// File: rtl/line_buffer_ram.sv
// Simple dual-port line RAM with a registered read port. The top address bit
// selects the ping-pong bank; the low bits select the pixel inside the bank.
module line_buffer_ram #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: the storage array and its read register carry no reset; stale
    // contents are never shown because bank-ready and the output stage are
    // reset, and a reset here would stop the array mapping onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/hdmi_line_fetch.sv
// Ping-pong line buffer between a memory fetch port and the HDMI pixel
// generator: fetches one line ahead and streams pixels with 2-cycle latency.
module hdmi_line_fetch
    import hdmi_pkg::*;
#(
    parameter int unsigned PIXELS_PER_LINE = H_ACTIVE,
    parameter int unsigned LINES_PER_FRAME = V_ACTIVE,
    parameter logic [15:0] UNDERRUN_COLOR  = 16'h001F
) (
    input  logic        pixelClockIn,
    input  logic        nReset,
    input  logic        requestPixel,
    input  logic        newScreen,
    input  logic        nextLine,
    input  logic        hSyncOut,
    input  logic        vSyncOut,
    input  logic [10:0] pixelIndex,
    output logic        fetchRequest,
    output logic [9:0]  fetchLine,
    input  logic        fetchAck,
    input  logic        wordValid,
    input  logic [15:0] wordData,
    output logic [4:0]  redIn,
    output logic [5:0]  greenIn,
    output logic [4:0]  blueIn,
    output logic        hSyncIn,
    output logic        vSyncIn,
    output logic        activeIn,
    output logic        underrun
);

    localparam logic [PIX_W-1:0]  LAST_WORD  = PIX_W'(PIXELS_PER_LINE - 1);
    localparam logic [LINE_W:0]   LINE_LIMIT = (LINE_W + 1)'(LINES_PER_FRAME);

    // Fetch side state
    fetch_state_e      state_q;
    logic [PIX_W-1:0]  word_count_q;
    logic              tgt_bank_q;
    logic [LINE_W-1:0] fetch_line_q;
    logic [1:0]        pend_q;
    logic [LINE_W-1:0] pend_line_q [2];
    logic [1:0]        bank_ready_q;
    logic              read_bank_q;
    logic [LINE_W-1:0] line_q;

    logic              last_word;
    logic              fetch_done;
    logic              launch;
    logic              pick_bank;
    logic [LINE_W:0]   line_plus2;
    logic              sched_next;
    logic              ram_we;

    // Display side pipeline
    logic              req_q1;
    logic              und_q1;
    logic              hs_q1;
    logic              vs_q1;
    rgb565_t           color_q;
    logic              hs_q2;
    logic              vs_q2;
    logic              act_q2;
    logic              underrun_q;
    logic [WORD_W-1:0] ram_rd_data;

    assign last_word  = wordValid && (word_count_q == LAST_WORD);
    assign fetch_done = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && last_word;
    assign launch     = (|pend_q) && ((state_q == ST_IDLE) || fetch_done);
    assign pick_bank  = ~pend_q[0];
    assign line_plus2 = {1'b0, line_q} + (LINE_W + 1)'(2);
    assign sched_next = line_plus2 < LINE_LIMIT;
    assign ram_we     = (state_q == ST_FILL) && wordValid && !newScreen;

    // NOTE: every register in this file uses non-blocking assignments, so each
    // statement below reads the pre-edge value and later writes win per bit.
    always_ff @(posedge pixelClockIn or negedge nReset) begin
        if (!nReset) begin
            state_q        <= ST_IDLE;
            word_count_q   <= '0;
            tgt_bank_q     <= 1'b0;
            fetch_line_q   <= '0;
            pend_q         <= 2'b00;
            pend_line_q[0] <= '0;
            pend_line_q[1] <= '0;
            bank_ready_q   <= 2'b00;
            read_bank_q    <= 1'b0;
            line_q         <= '0;
        end else if (newScreen) begin
            read_bank_q  <= 1'b0;
            bank_ready_q <= 2'b00;
            line_q       <= '0;
            if (((state_q == ST_FILL) || (state_q == ST_DRAIN)) && !last_word) begin
                // Words of the abandoned line are still in flight; swallow them.
                state_q        <= ST_DRAIN;
                pend_q         <= 2'b11;
                pend_line_q[0] <= LINE_W'(0);
                pend_line_q[1] <= LINE_W'(1);
                if (wordValid) begin
                    word_count_q <= word_count_q + PIX_W'(1);
                end
            end else begin
                state_q        <= ST_REQ;
                tgt_bank_q     <= 1'b0;
                fetch_line_q   <= '0;
                word_count_q   <= '0;
                pend_q         <= 2'b10;
                pend_line_q[1] <= LINE_W'(1);
            end
        end else begin
            if (nextLine) begin
                read_bank_q               <= ~read_bank_q;
                bank_ready_q[read_bank_q] <= 1'b0;
                line_q                    <= line_q + LINE_W'(1);
            end

            case (state_q)
                ST_IDLE: ;
                ST_REQ: begin
                    if (fetchAck) begin
                        state_q      <= ST_FILL;
                        word_count_q <= '0;
                    end
                end
                ST_FILL, ST_DRAIN: begin
                    if (wordValid) begin
                        if (last_word) begin
                            word_count_q <= '0;
                            state_q      <= ST_IDLE;
                            if (state_q == ST_FILL) begin
                                bank_ready_q[tgt_bank_q] <= 1'b1;
                            end
                        end else begin
                            word_count_q <= word_count_q + PIX_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (launch) begin
                state_q           <= ST_REQ;
                tgt_bank_q        <= pick_bank;
                fetch_line_q      <= pend_line_q[pick_bank];
                pend_q[pick_bank] <= 1'b0;
            end

            // The bank just released by the display is refilled two lines ahead.
            if (nextLine && sched_next) begin
                pend_q[read_bank_q]      <= 1'b1;
                pend_line_q[read_bank_q] <= line_plus2[LINE_W-1:0];
            end
        end
    end

    line_buffer_ram #(
        .ADDR_W (RAM_AW),
        .DATA_W (WORD_W)
    ) u_ram (
        .clk_i     (pixelClockIn),
        .wr_en_i   (ram_we),
        .wr_addr_i ({tgt_bank_q, word_count_q}),
        .wr_data_i (wordData),
        .rd_en_i   (requestPixel),
        .rd_addr_i ({read_bank_q, pixelIndex}),
        .rd_data_o (ram_rd_data)
    );

    // Stage 1 runs alongside the RAM read register; stage 2 drives the outputs.
    always_ff @(posedge pixelClockIn or negedge nReset) begin
        if (!nReset) begin
            req_q1     <= 1'b0;
            und_q1     <= 1'b0;
            hs_q1      <= 1'b0;
            vs_q1      <= 1'b0;
            color_q    <= '0;
            hs_q2      <= 1'b0;
            vs_q2      <= 1'b0;
            act_q2     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            req_q1 <= requestPixel;
            und_q1 <= requestPixel && !bank_ready_q[read_bank_q];
            hs_q1  <= hSyncOut;
            vs_q1  <= vSyncOut;
            hs_q2  <= hs_q1;
            vs_q2  <= vs_q1;
            act_q2 <= req_q1;

            if (und_q1) begin
                color_q <= rgb565_t'(UNDERRUN_COLOR);
            end else if (req_q1) begin
                color_q <= rgb565_t'(ram_rd_data);
            end else begin
                color_q <= '0;
            end

            if (requestPixel && !bank_ready_q[read_bank_q]) begin
                underrun_q <= 1'b1;
            end else if (newScreen) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign fetchRequest = (state_q == ST_REQ);
    assign fetchLine    = fetch_line_q;
    assign redIn        = color_q.red;
    assign greenIn      = color_q.green;
    assign blueIn       = color_q.blue;
    assign hSyncIn      = hs_q2;
    assign vSyncIn      = vs_q2;
    assign activeIn     = act_q2;
    assign underrun     = underrun_q;

endmodule
